// File: rtl/uart_fifo_pkg.sv
// Shared UART types and defaults.
// FSM state encoding used by both the RX and TX engines.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 326;
  localparam int DEF_FIFO_W  = 10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Head reads as 0 while empty; storage itself is never cleared.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DBIT   = DEF_DBIT,
  parameter int FIFO_W = DEF_FIFO_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  output logic            empty,
  output logic            full,
  output logic [DBIT-1:0] r_data
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam logic [FIFO_W:0]   CNT_ONE = 1;
  localparam logic [FIFO_W-1:0] PTR_ONE = 1;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr;
  logic [FIFO_W-1:0] rd_ptr;
  logic [FIFO_W:0]   count;
  logic              do_wr;
  logic              do_rd;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign empty  = (count == '0);
  assign full   = count[FIFO_W];
  assign do_rd  = rd && !empty;
  assign do_wr  = wr && (!full || do_rd);
  assign r_data = empty ? '0 : mem[rd_ptr];

  // storage write port
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= w_data;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with RX/TX FIFOs, shared 16x baud tick.
// Define UART_FRAME_CHECK_EN to drop bad-stop-bit bytes and pulse o_frame_err.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR,
  parameter int FIFO_W  = DEF_FIFO_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rd_uart,
  input  logic            i_wr_uart,
  input  logic            i_rx,
  input  logic [DBIT-1:0] i_w_data,
  output logic            o_tx_full,
  output logic            o_rx_empty,
  output logic            o_tx,
  output logic [DBIT-1:0] o_r_data,
  output logic            o_frame_err
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] B_LAST  = CW'(DVSR - 1);
  localparam logic [CW-1:0] B_ONE   = 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE   = 1;
  localparam logic [5:0]    S_MID   = 6'd7;
  localparam logic [5:0]    S_BIT   = 6'd15;
  localparam logic [5:0]    SB_LAST = 6'(SB_TICK - 1);
  localparam logic [5:0]    S_ONE   = 6'd1;

  logic [CW-1:0] baud_cnt;
  logic          tick;

  uart_state_t   rx_state;
  logic [5:0]    rx_s;
  logic [NW-1:0] rx_n;
  logic [DBIT-1:0] rx_b;
  logic          rx_done;
  logic          rx_push;
  logic          rx_full;

  uart_state_t   tx_state;
  logic [5:0]    tx_s;
  logic [NW-1:0] tx_n;
  logic [DBIT-1:0] tx_b;
  logic          tx_reg;
  logic          tx_empty;
  logic          tx_pop;
  logic          tx_stop_end;
  logic [DBIT-1:0] tx_head;

  assign tick = (baud_cnt == B_LAST);

  // free-running divider producing the 16x oversampling tick
  always_ff @(posedge i_clk) begin
    if (i_reset)     baud_cnt <= '0;
    else if (tick)   baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + B_ONE;
  end

  // receiver: find start centre, sample each bit centre, check stop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state <= IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          if (!i_rx) begin
            rx_state <= START;
            rx_s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s == S_MID) begin
              rx_s     <= '0;
              rx_n     <= '0;
              rx_state <= i_rx ? IDLE : DATA;
            end else begin
              rx_s <= rx_s + S_ONE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rx_s == S_BIT) begin
              rx_s <= '0;
              rx_b <= {i_rx, rx_b[DBIT-1:1]};
              if (rx_n == N_LAST) rx_state <= STOP;
              else                rx_n     <= rx_n + N_ONE;
            end else begin
              rx_s <= rx_s + S_ONE;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s == SB_LAST) begin
              rx_state <= IDLE;
              rx_done  <= 1'b1;
            end else begin
              rx_s <= rx_s + S_ONE;
            end
          end
        end
      endcase
    end
  end

`ifdef UART_FRAME_CHECK_EN
  logic stop_bad;

  // flags a low stop sample in the same cycle rx_done pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) stop_bad <= 1'b0;
    else         stop_bad <= (rx_state == STOP) && tick &&
                             (rx_s == SB_LAST) && !i_rx;
  end

  assign rx_push     = rx_done && !stop_bad && !rx_full;
  assign o_frame_err = stop_bad;
`else
  assign rx_push     = rx_done && !rx_full;
  assign o_frame_err = 1'b0;
`endif

  uart_sync_fifo #(
    .DBIT   (DBIT),
    .FIFO_W (FIFO_W)
  ) u_rx_fifo (
    .clk    (i_clk),
    .reset  (i_reset),
    .rd     (i_rd_uart),
    .wr     (rx_push),
    .w_data (rx_b),
    .empty  (o_rx_empty),
    .full   (rx_full),
    .r_data (o_r_data)
  );

  uart_sync_fifo #(
    .DBIT   (DBIT),
    .FIFO_W (FIFO_W)
  ) u_tx_fifo (
    .clk    (i_clk),
    .reset  (i_reset),
    .rd     (tx_pop),
    .wr     (i_wr_uart),
    .w_data (i_w_data),
    .empty  (tx_empty),
    .full   (o_tx_full),
    .r_data (tx_head)
  );

  // chaining straight from STOP into START avoids an idle gap
  assign tx_stop_end = (tx_state == STOP) && tick && (tx_s == SB_LAST);
  assign tx_pop      = !tx_empty && ((tx_state == IDLE) || tx_stop_end);
  assign o_tx        = tx_reg;

  // transmitter: start bit, LSB-first data, stop bits
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_reg   <= 1'b1;
    end else begin
      unique case (tx_state)
        IDLE: begin
          if (!tx_empty) begin
            tx_state <= START;
            tx_s     <= '0;
            tx_b     <= tx_head;
            tx_reg   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (tx_s == S_BIT) begin
              tx_state <= DATA;
              tx_s     <= '0;
              tx_n     <= '0;
              tx_reg   <= tx_b[0];
            end else begin
              tx_s <= tx_s + S_ONE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tx_s == S_BIT) begin
              tx_s <= '0;
              tx_b <= tx_b >> 1;
              if (tx_n == N_LAST) begin
                tx_state <= STOP;
                tx_reg   <= 1'b1;
              end else begin
                tx_n   <= tx_n + N_ONE;
                tx_reg <= tx_b[1];
              end
            end else begin
              tx_s <= tx_s + S_ONE;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tx_s == SB_LAST) begin
              tx_s <= '0;
              if (!tx_empty) begin
                tx_state <= START;
                tx_b     <= tx_head;
                tx_reg   <= 1'b0;
              end else begin
                tx_state <= IDLE;
              end
            end else begin
              tx_s <= tx_s + S_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: fast loopback instance plus default-rate instance.
module tb_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       f_rd, f_wr, f_loop, f_rx_drv, f_rx;
  logic [7:0] f_wdata, f_rdata;
  logic       f_tx_full, f_rx_empty, f_tx, f_ferr;

  logic       s_rd, s_wr, s_rx;
  logic [7:0] s_wdata, s_rdata;
  logic       s_tx_full, s_rx_empty, s_tx, s_ferr;

  assign f_rx = f_loop ? f_tx : f_rx_drv;

  uart_fifo #(
    .DBIT(8), .SB_TICK(16), .DVSR(2), .FIFO_W(2)
  ) u_fast (
    .i_clk(clk), .i_reset(rst),
    .i_rd_uart(f_rd), .i_wr_uart(f_wr),
    .i_rx(f_rx), .i_w_data(f_wdata),
    .o_tx_full(f_tx_full), .o_rx_empty(f_rx_empty),
    .o_tx(f_tx), .o_r_data(f_rdata),
    .o_frame_err(f_ferr)
  );

  uart_fifo u_slow (
    .i_clk(clk), .i_reset(rst),
    .i_rd_uart(s_rd), .i_wr_uart(s_wr),
    .i_rx(s_rx), .i_w_data(s_wdata),
    .o_tx_full(s_tx_full), .o_rx_empty(s_rx_empty),
    .o_tx(s_tx), .o_r_data(s_rdata),
    .o_frame_err(s_ferr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;

  always @(negedge clk) if (f_ferr) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_f(input logic [7:0] d);
    f_wdata = d;
    f_wr = 1'b1;
    cyc(1);
    f_wr = 1'b0;
  endtask

  task automatic pop_f();
    f_rd = 1'b1;
    cyc(1);
    f_rd = 1'b0;
  endtask

  task automatic wait_rx_f(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!f_rx_empty) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  // 32 clocks per bit at DVSR=2; a bad stop bit is held low only long
  // enough to cover its centre sample so it is not taken as a new start
  task automatic send_f(input logic [7:0] d, input bit stop_low);
    f_rx_drv = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      f_rx_drv = d[i];
      cyc(32);
    end
    if (stop_low) begin
      f_rx_drv = 1'b0;
      cyc(24);
      f_rx_drv = 1'b1;
      cyc(40);
    end else begin
      f_rx_drv = 1'b1;
      cyc(32);
    end
  endtask

  task automatic meas_s(input logic v, input int budget, output int n);
    n = 0;
    while (s_tx !== v && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    bit ok;
    int n;
    int fe_base;
    logic [7:0] exp_b [5];

    rst = 1'b1;
    f_rd = 0; f_wr = 0; f_wdata = 0; f_loop = 1; f_rx_drv = 1;
    s_rd = 0; s_wr = 0; s_wdata = 0; s_rx = 1;
    cyc(3);

    check("rst_tx", f_tx, 1);
    check("rst_rx_empty", f_rx_empty, 1);
    check("rst_tx_full", f_tx_full, 0);
    check("rst_r_data", f_rdata, 0);
    check("rst_ferr", f_ferr, 0);
    check("rst_slow_tx", s_tx, 1);
    rst = 1'b0;
    cyc(5);

    // loopback ordering
    wr_f(8'hFE);
    cyc(1);
    check("tx_fall", f_tx, 0);
    wr_f(8'h02);
    wait_rx_f(400, ok);
    check("lb1_arrive", ok, 1);
    check("lb1_data", f_rdata, 8'hFE);
    pop_f();
    wait_rx_f(400, ok);
    check("lb2_arrive", ok, 1);
    check("lb2_data", f_rdata, 8'h02);
    pop_f();
    check("lb_empty", f_rx_empty, 1);
    check("lb_r_data0", f_rdata, 0);
    cyc(40);

    // start glitch rejected
    f_loop = 1'b0;
    fe_base = fe_cnt;
    f_rx_drv = 1'b0;
    cyc(6);
    f_rx_drv = 1'b1;
    cyc(400);
    check("glitch_empty", f_rx_empty, 1);
    check("glitch_ferr", fe_cnt - fe_base, 0);

    // directly driven good frame
    send_f(8'h3C, 1'b0);
    wait_rx_f(40, ok);
    check("rx_good_arrive", ok, 1);
    check("rx_good_data", f_rdata, 8'h3C);
    pop_f();

    // bad stop bit
    fe_base = fe_cnt;
    send_f(8'hA5, 1'b1);
    cyc(20);
`ifdef UART_FRAME_CHECK_EN
    check("ferr_pulses", fe_cnt - fe_base, 1);
    check("ferr_empty", f_rx_empty, 1);
`else
    check("ferr_pulses", fe_cnt - fe_base, 0);
    check("ferr_kept", f_rx_empty, 0);
    check("ferr_data", f_rdata, 8'hA5);
    pop_f();
    check("ferr_empty", f_rx_empty, 1);
`endif

    // TX FIFO fills at 4 queued bytes, extra write dropped
    f_loop = 1'b1;
    cyc(10);
    wr_f(8'h11);
    cyc(3);
    check("full_0", f_tx_full, 0);
    wr_f(8'h22);
    wr_f(8'h33);
    wr_f(8'h44);
    check("full_3", f_tx_full, 0);
    wr_f(8'h55);
    check("full_4", f_tx_full, 1);
    wr_f(8'h66);
    check("full_5", f_tx_full, 1);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      wait_rx_f(400, ok);
      check($sformatf("txq_arrive%0d", i), ok, 1);
      check($sformatf("txq_data%0d", i), f_rdata, exp_b[i]);
      pop_f();
    end
    cyc(400);
    check("txq_no_sixth", f_rx_empty, 1);

    // RX FIFO full: fifth byte dropped, stored bytes intact
    exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 5; i++) wr_f(exp_b[i]);
    cyc(1750);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rxfull_data%0d", i), f_rdata, exp_b[i]);
      pop_f();
    end
    check("rxfull_drop", f_rx_empty, 1);

    // reset during data bits
    wr_f(8'h5A);
    wait_rx_f(400, ok);
    check("mid_pre_arrive", ok, 1);
    cyc(40);
    wr_f(8'hB1);
    wr_f(8'hB2);
    wr_f(8'hB3);
    wr_f(8'hB4);
    wr_f(8'hB5);
    cyc(100);
    check("mid_pre_full", f_tx_full, 1);
    check("mid_pre_tx", f_tx, 0);
    check("mid_pre_rx", f_rx_empty, 0);
    rst = 1'b1;
    cyc(1);
    check("mid_tx", f_tx, 1);
    check("mid_rx_empty", f_rx_empty, 1);
    check("mid_tx_full", f_tx_full, 0);
    check("mid_r_data", f_rdata, 0);
    rst = 1'b0;
    cyc(400);
    check("mid_post_rx", f_rx_empty, 1);
    check("mid_post_tx", f_tx, 1);

    // default-rate frame for 0x3F; start bit length depends on baud phase
    s_wdata = 8'h3F;
    s_wr = 1'b1;
    cyc(1);
    s_wr = 1'b0;
    meas_s(1'b0, 4, n);
    check("s_fall_lat", 32'(s_tx == 1'b0 && n >= 1 && n <= 2), 1);
    meas_s(1'b1, 6000, n);
    check("s_start_len", 32'(n >= 4891 && n <= 5216), 1);
    meas_s(1'b0, 40000, n);
    check("s_ones_len", n, 31296);
    meas_s(1'b1, 12000, n);
    check("s_zeros_len", n, 10432);
    meas_s(1'b0, 6000, n);
    check("s_idle_after", n, 6000);
    check("s_tx_full", s_tx_full, 0);
    check("s_rx_empty", s_rx_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
